// File: rtl/bus_pkg.sv
// Shared definitions for the two-port bus arbiter: FSM state encodings and
// transfer-mode constants.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUSY_FETCH = 2'd1,
    ST_BUSY_MEM   = 2'd2
  } arb_state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/req_slot.sv
// One-entry pending-request holder: captures a request's fields on a pulse
// and drops them once the arbiter has issued it downstream.
module req_slot
  import bus_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        capture_i,
  input  logic        clear_i,
  input  logic        mode_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        valid_o,
  output logic        mode_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o
);

  logic        valid_q;
  logic        mode_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      mode_q  <= MODE_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (capture_i) begin
      valid_q <= 1'b1;
      mode_q  <= mode_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      wstrb_q <= wstrb_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign wstrb_o = wstrb_q;

endmodule

// File: rtl/bus_arbiter.sv
// Merges the fetch and data-side request ports onto a single downstream port
// with one transaction outstanding; data side wins when both are waiting.
module bus_arbiter
  import bus_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,
  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data,
  output logic        request_enable,
  output logic        req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        response_enable,
  input  logic [31:0] resp_data
);

  arb_state_e  state_q;
  logic        request_enable_q, req_mode_q;
  logic [31:0] req_addr_q, req_wdata_q;
  logic [3:0]  req_wstrb_q;
  logic        fetch_response_enable_q, mem_response_enable_q;
  logic [31:0] fresp_data_q, mresp_data_q;

  logic        f_valid, f_mode_s, m_valid, m_mode_s;
  logic [31:0] f_addr_s, f_wdata_s, m_addr_s, m_wdata_s;
  logic [3:0]  f_wstrb_s, m_wstrb_s;

  logic idle, f_busy, m_busy, done;
  logic f_accept, m_accept;
  logic issue_fetch, issue_mem;

  assign idle   = (state_q == ST_IDLE);
  assign f_busy = (state_q == ST_BUSY_FETCH);
  assign m_busy = (state_q == ST_BUSY_MEM);
  assign done   = !idle && response_enable;

  // A pulse is taken only if its slot is empty and it has nothing in flight,
  // except that the completing cycle frees the requester immediately.
  assign f_accept = fetch_request_enable && !f_valid && !(f_busy && !response_enable);
  assign m_accept = mem_request_enable   && !m_valid && !(m_busy && !response_enable);

  // On a completion only slots already waiting are chained; pulses arriving in
  // that same cycle are parked and go out from IDLE.
  always_comb begin
    issue_mem   = 1'b0;
    issue_fetch = 1'b0;
    if (idle) begin
      if (m_valid || m_accept)      issue_mem   = 1'b1;
      else if (f_valid || f_accept) issue_fetch = 1'b1;
    end else if (done) begin
      if (f_busy && m_valid)        issue_mem   = 1'b1;
      else if (m_busy && f_valid)   issue_fetch = 1'b1;
    end
  end

  req_slot u_fetch_slot (
    .clk       (clk),
    .rstn      (rstn),
    .capture_i (f_accept && !issue_fetch),
    .clear_i   (issue_fetch && f_valid),
    .mode_i    (freq_mode),
    .addr_i    (freq_addr),
    .wdata_i   (freq_wdata),
    .wstrb_i   (freq_wstrb),
    .valid_o   (f_valid),
    .mode_o    (f_mode_s),
    .addr_o    (f_addr_s),
    .wdata_o   (f_wdata_s),
    .wstrb_o   (f_wstrb_s)
  );

  req_slot u_mem_slot (
    .clk       (clk),
    .rstn      (rstn),
    .capture_i (m_accept && !issue_mem),
    .clear_i   (issue_mem && m_valid),
    .mode_i    (mreq_mode),
    .addr_i    (mreq_addr),
    .wdata_i   (mreq_wdata),
    .wstrb_i   (mreq_wstrb),
    .valid_o   (m_valid),
    .mode_o    (m_mode_s),
    .addr_o    (m_addr_s),
    .wdata_o   (m_wdata_s),
    .wstrb_o   (m_wstrb_s)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q                 <= ST_IDLE;
      request_enable_q        <= 1'b0;
      req_mode_q              <= MODE_READ;
      req_addr_q              <= '0;
      req_wdata_q             <= '0;
      req_wstrb_q             <= '0;
      fetch_response_enable_q <= 1'b0;
      mem_response_enable_q   <= 1'b0;
      fresp_data_q            <= '0;
      mresp_data_q            <= '0;
    end else begin
      request_enable_q        <= issue_mem || issue_fetch;
      fetch_response_enable_q <= done && f_busy;
      mem_response_enable_q   <= done && m_busy;
      if (done && f_busy) fresp_data_q <= resp_data;
      if (done && m_busy) mresp_data_q <= resp_data;

      if (issue_mem) begin
        state_q     <= ST_BUSY_MEM;
        req_mode_q  <= m_valid ? m_mode_s  : mreq_mode;
        req_addr_q  <= m_valid ? m_addr_s  : mreq_addr;
        req_wdata_q <= m_valid ? m_wdata_s : mreq_wdata;
        req_wstrb_q <= m_valid ? m_wstrb_s : mreq_wstrb;
      end else if (issue_fetch) begin
        state_q     <= ST_BUSY_FETCH;
        req_mode_q  <= f_valid ? f_mode_s  : freq_mode;
        req_addr_q  <= f_valid ? f_addr_s  : freq_addr;
        req_wdata_q <= f_valid ? f_wdata_s : freq_wdata;
        req_wstrb_q <= f_valid ? f_wstrb_s : freq_wstrb;
      end else if (done) begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign request_enable        = request_enable_q;
  assign req_mode              = req_mode_q;
  assign req_addr              = req_addr_q;
  assign req_wdata             = req_wdata_q;
  assign req_wstrb             = req_wstrb_q;
  assign fetch_response_enable = fetch_response_enable_q;
  assign mem_response_enable   = mem_response_enable_q;
  assign fresp_data            = fresp_data_q;
  assign mresp_data            = mresp_data_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with fixed expectations, then a
// randomized run checked against a queue-based transaction model.
module tb_bus_arbiter;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_request_enable, freq_mode;
  logic [31:0] freq_addr, freq_wdata;
  logic [3:0]  freq_wstrb;
  logic        fetch_response_enable;
  logic [31:0] fresp_data;
  logic        mem_request_enable, mreq_mode;
  logic [31:0] mreq_addr, mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mem_response_enable;
  logic [31:0] mresp_data;
  logic        request_enable, req_mode;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;

  bus_arbiter dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .fetch_request_enable  (fetch_request_enable),
    .freq_mode             (freq_mode),
    .freq_addr             (freq_addr),
    .freq_wdata            (freq_wdata),
    .freq_wstrb            (freq_wstrb),
    .fetch_response_enable (fetch_response_enable),
    .fresp_data            (fresp_data),
    .mem_request_enable    (mem_request_enable),
    .mreq_mode             (mreq_mode),
    .mreq_addr             (mreq_addr),
    .mreq_wdata            (mreq_wdata),
    .mreq_wstrb            (mreq_wstrb),
    .mem_response_enable   (mem_response_enable),
    .mresp_data            (mresp_data),
    .request_enable        (request_enable),
    .req_mode              (req_mode),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .req_wstrb             (req_wstrb),
    .response_enable       (response_enable),
    .resp_data             (resp_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } rq_t;

  // Transaction model: each requester's accepted-but-unissued work as a queue,
  // plus who owns the downstream port (-1 = nobody).
  rq_t         q_f[$];
  rq_t         q_m[$];
  int          m_owner;
  int          m_accepted;
  logic        exp_req_en, exp_fr, exp_mr;
  rq_t         exp_req;
  logic [31:0] exp_fdata, exp_mdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_request_enable = 0; freq_mode = 0; freq_addr = 0; freq_wdata = 0; freq_wstrb = 0;
    mem_request_enable = 0;   mreq_mode = 0; mreq_addr = 0; mreq_wdata = 0; mreq_wstrb = 0;
    response_enable = 0;      resp_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 0;
    tick();
    rstn = 1;
    tick();
  endtask

  task automatic model_reset();
    q_f.delete(); q_m.delete();
    m_owner = -1; m_accepted = 0;
    exp_req_en = 0; exp_fr = 0; exp_mr = 0;
    exp_req = '0; exp_fdata = 0; exp_mdata = 0;
  endtask

  // Predict outputs of the coming edge from the inputs currently driven.
  task automatic model_step();
    bit was_idle, finishing, had_f, had_m;
    int pick;
    was_idle  = (m_owner == -1);
    finishing = !was_idle && response_enable;
    had_f = (q_f.size() != 0);
    had_m = (q_m.size() != 0);
    exp_fr = 0; exp_mr = 0; exp_req_en = 0;
    if (finishing) begin
      if (m_owner == 0) begin exp_fr = 1; exp_fdata = resp_data; end
      else              begin exp_mr = 1; exp_mdata = resp_data; end
      m_owner = -1;
    end
    if (fetch_request_enable && q_f.size() == 0 && m_owner != 0) begin
      q_f.push_back({freq_mode, freq_addr, freq_wdata, freq_wstrb});
      m_accepted++;
    end
    if (mem_request_enable && q_m.size() == 0 && m_owner != 1) begin
      q_m.push_back({mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb});
      m_accepted++;
    end
    pick = -1;
    if (was_idle) pick = (q_m.size() != 0) ? 1 : ((q_f.size() != 0) ? 0 : -1);
    else if (finishing) pick = had_m ? 1 : (had_f ? 0 : -1);
    if (pick == 1) begin exp_req = q_m.pop_front(); exp_req_en = 1; m_owner = 1; end
    if (pick == 0) begin exp_req = q_f.pop_front(); exp_req_en = 1; m_owner = 0; end
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 0;
    tick(); tick();
    checks++; if (request_enable !== 1'b0) begin errors++; $display("FAIL reset_req_en got %b want 0", request_enable); end
    checks++; if ({req_mode, req_addr, req_wdata, req_wstrb} !== 69'd0) begin errors++; $display("FAIL reset_req_fields got %h want 0", {req_mode, req_addr, req_wdata, req_wstrb}); end
    checks++; if ({fetch_response_enable, mem_response_enable} !== 2'b00) begin errors++; $display("FAIL reset_resp_en got %b want 00", {fetch_response_enable, mem_response_enable}); end
    checks++; if ({fresp_data, mresp_data} !== 64'd0) begin errors++; $display("FAIL reset_resp_data got %h want 0", {fresp_data, mresp_data}); end
    rstn = 1;
    tick();
  endtask

  task automatic test_fetch_read();
    fetch_request_enable = 1; freq_mode = MODE_READ; freq_addr = 32'h0000_1000;
    tick(); clear_inputs();
    checks++; if (request_enable !== 1'b1) begin errors++; $display("FAIL fetch_issue_en got %b want 1", request_enable); end
    checks++; if (req_addr !== 32'h1000 || req_mode !== 1'b0) begin errors++; $display("FAIL fetch_issue_fields got addr %h mode %b want 00001000 0", req_addr, req_mode); end
    tick();
    checks++; if (request_enable !== 1'b0) begin errors++; $display("FAIL fetch_issue_width got %b want 0", request_enable); end
    tick();
    response_enable = 1; resp_data = 32'hDEADBEEF;
    tick(); clear_inputs();
    checks++; if (fetch_response_enable !== 1'b1 || fresp_data !== 32'hDEADBEEF || mem_response_enable !== 1'b0) begin
      errors++; $display("FAIL fetch_resp got en %b data %h men %b want 1 deadbeef 0", fetch_response_enable, fresp_data, mem_response_enable); end
    tick();
    checks++; if (fetch_response_enable !== 1'b0 || fresp_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fetch_resp_hold got en %b data %h want 0 deadbeef", fetch_response_enable, fresp_data); end
  endtask

  task automatic test_simultaneous();
    fetch_request_enable = 1; freq_addr = 32'h100;
    mem_request_enable = 1; mreq_mode = MODE_WRITE; mreq_addr = 32'h8000_0000;
    mreq_wdata = 32'h1234_5678; mreq_wstrb = 4'hF;
    tick(); clear_inputs();
    checks++; if (request_enable !== 1'b1 || {req_mode, req_addr, req_wdata, req_wstrb} !== {1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF}) begin
      errors++; $display("FAIL simul_mem_first got en %b mode %b addr %h wdata %h wstrb %h", request_enable, req_mode, req_addr, req_wdata, req_wstrb); end
    tick(); tick();
    response_enable = 1; resp_data = 32'h0000_0055;
    tick(); clear_inputs();
    checks++; if (mem_response_enable !== 1'b1 || mresp_data !== 32'h55 || fetch_response_enable !== 1'b0) begin
      errors++; $display("FAIL simul_mem_resp got men %b data %h fen %b want 1 00000055 0", mem_response_enable, mresp_data, fetch_response_enable); end
    checks++; if (request_enable !== 1'b1 || req_addr !== 32'h100 || req_mode !== 1'b0) begin
      errors++; $display("FAIL simul_fetch_b2b got en %b addr %h mode %b want 1 00000100 0", request_enable, req_addr, req_mode); end
    response_enable = 1; resp_data = 32'hCAFE_0001;
    tick(); clear_inputs();
    checks++; if (fetch_response_enable !== 1'b1 || fresp_data !== 32'hCAFE_0001 || request_enable !== 1'b0) begin
      errors++; $display("FAIL simul_fetch_resp got fen %b data %h req %b want 1 cafe0001 0", fetch_response_enable, fresp_data, request_enable); end
  endtask

  task automatic test_capture_while_busy();
    fetch_request_enable = 1; freq_addr = 32'h200;
    tick(); clear_inputs();
    mem_request_enable = 1; mreq_addr = 32'h4000_0040;
    tick(); clear_inputs();
    for (int i = 0; i < 3; i++) begin
      checks++; if (request_enable !== 1'b0 || mem_response_enable !== 1'b0) begin
        errors++; $display("FAIL busy_hold[%0d] got req %b men %b want 0 0", i, request_enable, mem_response_enable); end
      tick();
    end
    response_enable = 1; resp_data = 32'hA5A5_0002;
    tick(); clear_inputs();
    checks++; if (fetch_response_enable !== 1'b1 || request_enable !== 1'b1 || req_addr !== 32'h4000_0040 || mem_response_enable !== 1'b0) begin
      errors++; $display("FAIL busy_mem_issue got fen %b req %b addr %h men %b", fetch_response_enable, request_enable, req_addr, mem_response_enable); end
    response_enable = 1; resp_data = 32'h0BAD_F00D;
    tick(); clear_inputs();
    checks++; if (mem_response_enable !== 1'b1 || mresp_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL busy_mem_resp got %b %h want 1 0badf00d", mem_response_enable, mresp_data); end
  endtask

  task automatic test_violation_and_same_cycle();
    fetch_request_enable = 1; freq_addr = 32'h300;
    tick(); clear_inputs();
    fetch_request_enable = 1; freq_addr = 32'h304;
    tick(); clear_inputs();
    response_enable = 1; resp_data = 32'h1;
    fetch_request_enable = 1; freq_addr = 32'h308;
    tick(); clear_inputs();
    checks++; if (fetch_response_enable !== 1'b1 || request_enable !== 1'b0) begin
      errors++; $display("FAIL same_cycle_resp got fen %b req %b want 1 0", fetch_response_enable, request_enable); end
    tick();
    checks++; if (request_enable !== 1'b1 || req_addr !== 32'h308) begin
      errors++; $display("FAIL same_cycle_reissue got req %b addr %h want 1 00000308", request_enable, req_addr); end
    response_enable = 1;
    tick(); clear_inputs();
    tick();
    checks++; if (request_enable !== 1'b0) begin
      errors++; $display("FAIL violation_dropped got req %b want 0", request_enable); end
  endtask

  task automatic test_idle_response();
    response_enable = 1; resp_data = 32'hFFFF_FFFF;
    tick(); clear_inputs();
    checks++; if ({fetch_response_enable, mem_response_enable} !== 2'b00 || fresp_data === 32'hFFFF_FFFF) begin
      errors++; $display("FAIL idle_resp got en %b fdata %h want 00 and unchanged", {fetch_response_enable, mem_response_enable}, fresp_data); end
    mem_request_enable = 1; mreq_addr = 32'h500;
    tick(); clear_inputs();
    checks++; if (request_enable !== 1'b1 || req_addr !== 32'h500) begin
      errors++; $display("FAIL idle_after_resp got req %b addr %h want 1 00000500", request_enable, req_addr); end
    response_enable = 1;
    tick(); clear_inputs();
  endtask

  task automatic test_reset_mid();
    mem_request_enable = 1; mreq_mode = MODE_WRITE; mreq_addr = 32'h9000_0000;
    mreq_wdata = 32'h7777_7777; mreq_wstrb = 4'h3;
    tick(); clear_inputs();
    #2 rstn = 0;
    #1;
    checks++; if ({request_enable, req_mode, req_addr, req_wdata, req_wstrb} !== 70'd0) begin
      errors++; $display("FAIL midreset_req got %h want 0", {request_enable, req_mode, req_addr, req_wdata, req_wstrb}); end
    checks++; if ({fetch_response_enable, mem_response_enable, fresp_data, mresp_data} !== 66'd0) begin
      errors++; $display("FAIL midreset_resp got %h want 0", {fetch_response_enable, mem_response_enable, fresp_data, mresp_data}); end
    tick();
    rstn = 1;
    response_enable = 1; resp_data = 32'h1234;
    tick(); clear_inputs();
    checks++; if ({fetch_response_enable, mem_response_enable, request_enable} !== 3'b000) begin
      errors++; $display("FAIL late_resp got %b want 000", {fetch_response_enable, mem_response_enable, request_enable}); end
    fetch_request_enable = 1; freq_addr = 32'h600;
    tick(); clear_inputs();
    checks++; if (request_enable !== 1'b1 || req_addr !== 32'h600) begin
      errors++; $display("FAIL post_reset_fetch got req %b addr %h want 1 00000600", request_enable, req_addr); end
    response_enable = 1;
    tick(); clear_inputs();
  endtask

  task automatic test_random();
    int cd = 0;
    int cycles = 0;
    int dut_issues = 0;
    int dut_resps = 0;
    do_reset();
    model_reset();
    while ((m_accepted < 1000 || m_owner != -1 || q_f.size() != 0 || q_m.size() != 0) && cycles < 30000) begin
      clear_inputs();
      if (m_accepted < 1000) begin
        if ($urandom_range(0, 2) == 0) begin
          fetch_request_enable = 1; freq_mode = 1'($urandom_range(0, 1));
          freq_addr = $urandom; freq_wdata = $urandom; freq_wstrb = 4'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 2) == 0) begin
          mem_request_enable = 1; mreq_mode = 1'($urandom_range(0, 1));
          mreq_addr = $urandom; mreq_wdata = $urandom; mreq_wstrb = 4'($urandom_range(0, 15));
        end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin response_enable = 1; resp_data = $urandom; end
      end
      model_step();
      tick();
      cycles++;
      checks++; if (request_enable !== exp_req_en) begin
        errors++; $display("FAIL rnd_req_en cyc %0d got %b want %b", cycles, request_enable, exp_req_en); end
      if (exp_req_en) begin
        checks++; if ({req_mode, req_addr, req_wdata, req_wstrb} !== exp_req) begin
          errors++; $display("FAIL rnd_req_fields cyc %0d got %h want %h", cycles, {req_mode, req_addr, req_wdata, req_wstrb}, exp_req); end
      end
      checks++; if ({fetch_response_enable, mem_response_enable} !== {exp_fr, exp_mr}) begin
        errors++; $display("FAIL rnd_resp_en cyc %0d got %b want %b", cycles, {fetch_response_enable, mem_response_enable}, {exp_fr, exp_mr}); end
      checks++; if (fresp_data !== exp_fdata || mresp_data !== exp_mdata) begin
        errors++; $display("FAIL rnd_resp_data cyc %0d got %h %h want %h %h", cycles, fresp_data, mresp_data, exp_fdata, exp_mdata); end
      if (request_enable) begin dut_issues++; cd = $urandom_range(1, 5) + 1; end
      dut_resps += int'(fetch_response_enable) + int'(mem_response_enable);
    end
    clear_inputs();
    checks++; if (cycles >= 30000) begin
      errors++; $display("FAIL rnd_timeout got %0d cycles want under 30000", cycles); end
    checks++; if (dut_issues != m_accepted || dut_resps != m_accepted) begin
      errors++; $display("FAIL rnd_totals got issues %0d resps %0d want %0d", dut_issues, dut_resps, m_accepted); end
  endtask

  initial begin
    clear_inputs();
    rstn = 0;
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_capture_while_busy();
    test_violation_and_same_cycle();
    test_idle_response();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
